// File: rtl/inst_mem_loader_if.sv
// Host-loader and fetch handshake bundle for inst_mem_loader.
// master = host/fetch side, slave = the memory.
interface inst_mem_loader_if #(
   parameter int DEPTH = 256
);
   localparam int AW = $clog2(DEPTH);

   logic          load_start;
   logic          load_byte_valid;
   logic [7:0]    load_byte;
   logic          load_byte_ready;
   logic          load_done;
   logic          load_overflow;
   logic [AW:0]   loaded_words;
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_ready;
   logic [31:0]   inst;
   logic          inst_valid;
   logic          fetch_fault;
   logic          busy;

   modport master (
      output load_start, load_byte_valid, load_byte, load_done, fetch_req, fetch_addr,
      input  load_byte_ready, load_overflow, loaded_words, fetch_ready, inst, inst_valid,
             fetch_fault, busy
   );

   modport slave (
      input  load_start, load_byte_valid, load_byte, load_done, fetch_req, fetch_addr,
      output load_byte_ready, load_overflow, loaded_words, fetch_ready, inst, inst_valid,
             fetch_fault, busy
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Loadable instruction memory: scrub-to-NOP after clear, little-endian byte-stream
// loader, and a registered fetch port that returns NOP with a fault flag on bad addresses.
module inst_mem_loader #(
   parameter int          DEPTH = 256,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input logic               clk,
   input logic               clear,
   inst_mem_loader_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_LOAD} state_t;

   state_t        state, state_next;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] scrub_ptr;
   logic [AW:0]   wr_ptr;
   logic [1:0]    byte_cnt;
   logic [31:0]   asm_word;
   logic [AW:0]   loaded_words;
   logic          load_overflow;
   logic [31:0]   inst;
   logic          inst_valid;
   logic          fetch_fault;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic          byte_ready;
   logic          byte_take;
   logic          fetch_take;
   logic          fetch_bad;
   logic [31:0]   word_merged;
   logic [2:0]    cnt_merged;

   assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr[31:AW+2] != '0);

   always_ff @(posedge clk) begin
      if (clear) state <= S_INIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      mem_we      = 1'b0;
      mem_waddr   = scrub_ptr;
      mem_wdata   = NOP;
      byte_ready  = 1'b0;
      byte_take   = 1'b0;
      fetch_take  = 1'b0;
      word_merged = asm_word;
      cnt_merged  = {1'b0, byte_cnt};
      case (state)
         S_INIT: begin
            mem_we = 1'b1;
            if (scrub_ptr == AW'(DEPTH - 1)) state_next = S_RUN;
         end
         S_RUN: begin
            fetch_take = bus.fetch_req;
            if (bus.load_start) state_next = S_LOAD;
         end
         S_LOAD: begin
            byte_ready = ~wr_ptr[AW];
            byte_take  = bus.load_byte_valid & byte_ready;
            if (byte_take) begin
               word_merged[8*byte_cnt +: 8] = bus.load_byte;
               cnt_merged = {1'b0, byte_cnt} + 3'd1;
            end
            // A byte arriving together with load_done is folded into the final word.
            mem_waddr = wr_ptr[AW-1:0];
            mem_wdata = word_merged;
            mem_we    = cnt_merged[2] | (bus.load_done & (cnt_merged != 3'd0));
            if (bus.load_done) state_next = S_RUN;
         end
         default: state_next = S_INIT;
      endcase
      if (clear) mem_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (state == S_RUN && bus.load_start) asm_word <= '0;
      else if (state == S_LOAD) begin
         if (mem_we)         asm_word <= '0;
         else if (byte_take) asm_word <= word_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         scrub_ptr     <= '0;
         wr_ptr        <= '0;
         byte_cnt      <= '0;
         loaded_words  <= '0;
         load_overflow <= 1'b0;
         inst          <= '0;
         inst_valid    <= 1'b0;
         fetch_fault   <= 1'b0;
      end else begin
         inst_valid <= fetch_take;
         if (state == S_INIT) scrub_ptr <= scrub_ptr + 1'b1;
         if (state == S_RUN && bus.load_start) begin
            wr_ptr        <= '0;
            byte_cnt      <= '0;
            loaded_words  <= '0;
            load_overflow <= 1'b0;
         end
         if (state == S_LOAD) begin
            if (mem_we) begin
               wr_ptr       <= wr_ptr + 1'b1;
               loaded_words <= loaded_words + 1'b1;
               byte_cnt     <= '0;
            end else if (byte_take) begin
               byte_cnt <= cnt_merged[1:0];
            end
            if (bus.load_byte_valid && !byte_ready) load_overflow <= 1'b1;
         end
         if (fetch_take) begin
            fetch_fault <= fetch_bad;
            inst        <= fetch_bad ? NOP : mem[bus.fetch_addr[AW+1:2]];
         end
      end
   end

   assign bus.fetch_ready     = (state == S_RUN);
   assign bus.load_byte_ready = byte_ready;
   assign bus.busy            = (state != S_RUN);
   assign bus.load_overflow   = load_overflow;
   assign bus.loaded_words    = loaded_words;
   assign bus.inst            = inst;
   assign bus.inst_valid      = inst_valid;
   assign bus.fetch_fault     = fetch_fault;
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Parametrised, loadable instruction memory for the single-cycle RISC-V core. It replaces the hard-coded combinational ROM with synchronous storage that has three parts: a reset-time scrub to NOP, a byte-stream program loader driven by a host/UART front end, and a registered fetch port with fault reporting. It sits between the PC/fetch logic and the boot/debug host.

## Interface
Parameters
- DEPTH, 256, number of 32-bit words; power of two, at least 4; AW = log2(DEPTH)
- NOP, 32'h00000013, scrub value and the instruction returned on a faulting fetch

Ports
- clk  in  1  rising-edge clock
- clear  in  1  reset; synchronous, active-high
- load_start  in  1  request to enter LOAD from RUN
- load_byte_valid  in  1  load_byte is valid
- load_byte  in  8  program byte; little-endian, LSB of each word first
- load_byte_ready  out  1  byte accepted when valid && ready
- load_done  in  1  host ends the load
- load_overflow  out  1  sticky; a byte was offered while memory was full
- loaded_words  out  AW+1  words written in the last or current load
- fetch_req  in  1  fetch request
- fetch_addr  in  32  byte address
- fetch_ready  out  1  fetch accepted when req && ready
- inst  out  32  fetched instruction; holds its value between fetches
- inst_valid  out  1  one-cycle pulse per accepted fetch
- fetch_fault  out  1  qualifies inst_valid; misaligned or out-of-range address
- busy  out  1  high in INIT and LOAD

## Operation
States
- INIT: entered on clear. Writes NOP to word scrub_ptr each cycle, scrub_ptr 0..DEPTH-1. After the write to DEPTH-1, goes to RUN. load_start is ignored.
- RUN: fetch_ready = 1.
  - load_start = 1: go to LOAD; wr_ptr, byte_cnt and loaded_words are cleared; load_overflow is cleared.
  - Memory is not re-scrubbed; words beyond the loaded image keep their old contents.
- LOAD: fetch_ready = 0.
  - load_byte_ready = (wr_ptr < DEPTH).
  - Each accepted byte goes into the assembly register at lane byte_cnt, and byte_cnt increments.
  - On the 4th byte, the full word is written to mem[wr_ptr]; then wr_ptr++, loaded_words++, byte_cnt = 0.
  - While full (wr_ptr == DEPTH), load_byte_ready = 0. A valid byte sets load_overflow and is dropped.
  - load_done = 1: if byte_cnt != 0, the partial word is written with zero upper lanes and counted, then go to RUN. If byte_cnt == 0, go straight to RUN.
  - If load_done and load_byte_valid are both asserted (and ready is high), the byte is taken first and included in the final word.
- Fetch (RUN only), on an accepted fetch:
  - Fault when fetch_addr[1:0] != 0 or fetch_addr[31:AW+2] != 0.
  - Fault: inst = NOP, fetch_fault = 1.
  - No fault: inst = mem[fetch_addr[AW+1:2]], fetch_fault = 0.
  - inst_valid pulses.
- Simultaneous events in RUN:
  - fetch_req and load_start in the same cycle: the fetch is accepted and its response appears next cycle, in LOAD.
- Reset mid-operation: clear at any cycle aborts INIT, LOAD or a fetch and restarts INIT from word 0. Partially loaded data is overwritten by the scrub.
- Memory has a single write port. The write source is the scrub in INIT and the loader in LOAD; no writes occur in RUN.

## Timing
Reset values (cycle after clear is sampled high)
- inst = 0, inst_valid = 0, fetch_fault = 0, load_overflow = 0, loaded_words = 0
- busy = 1, fetch_ready = 0, load_byte_ready = 0

Latencies
- INIT lasts exactly DEPTH cycles after clear deasserts; fetch_ready rises on cycle DEPTH+1.
- Fetch: 1 cycle, request at edge N gives inst/inst_valid after edge N+1; back-to-back fetches give one result per cycle.
- Byte to write: the word is written at the edge that accepts its 4th byte. A fetch in RUN sees all loaded words.
- LOAD exit: 1 cycle after load_done (partial write included); fetch_ready rises the following cycle.
- load_start to load_byte_ready: 1 cycle.
- Outputs are registered; no combinational path from fetch_addr to inst.

## Test plan
- Scrub: clear 1 cycle, DEPTH=256. After 256 cycles, fetch 0x000 and 0x3FC -> inst=0x00000013, fault=0, busy falls exactly at cycle 256.
- Load and fetch:
  - Load bytes 37 00 00 00 B7 00 00 00 03 21 00 02, then load_done.
  - loaded_words = 3.
  - Fetches at 0x0, 0x4, 0x8 -> 0x00000037, 0x000000B7, 0x02002103, each valid 1 cycle after request.
- Partial word: load 5 bytes 11 22 33 44 55 + load_done -> loaded_words = 2; fetch 0x4 -> 0x00000055.
- Faults:
  - fetch 0x2 -> inst=0x00000013, fault=1.
  - fetch 0x400 with DEPTH=256 -> fault=1.
  - fetch 0x3FC -> fault=0.
- Overflow: DEPTH=4, load 20 bytes -> load_byte_ready low after byte 16, load_overflow=1, loaded_words=4, word 3 intact.
- Mid-load reset: assert clear after 6 bytes -> INIT restarts; afterwards fetch 0x0 -> 0x00000013.
